// File: rtl/sha256_w_sched.sv
// SHA-256 message-schedule generator: loads one 512-bit block and presents W[t]
// alongside round index t for rounds 0..63, using a sliding 16-word window.
module sha256_w_sched (
  input  logic         clk,
  input  logic         reset,
  input  logic [511:0] block,
  input  logic         init,
  input  logic         next,
  output logic [31:0]  w,
  output logic [5:0]   round,
  output logic         w_valid,
  output logic         done
);

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_WORDS = 16;
  localparam int unsigned ROUND_W   = 6;

  logic [WORD_W-1:0]  w_mem     [NUM_WORDS];
  logic [WORD_W-1:0]  w_mem_nxt [NUM_WORDS];
  logic [ROUND_W-1:0] round_nxt;
  logic               w_valid_nxt;
  logic               done_nxt;
  logic [WORD_W-1:0]  w_new;

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // Next schedule word from the current window (window holds W[t-16..t-1])
  always_comb begin
    w_new = sigma1(w_mem[14]) + w_mem[9] + sigma0(w_mem[1]) + w_mem[0];
  end

  // Rounds 0..15 read the loaded words directly; later rounds use the fresh word
  always_comb begin
    w = w_new;
    if (round[5:4] == 2'b00) begin
      w = w_mem[round[3:0]];
    end
  end

  always_comb begin
    w_mem_nxt   = w_mem;
    round_nxt   = round;
    w_valid_nxt = w_valid;
    done_nxt    = 1'b0;
    if (init) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        w_mem_nxt[i] = block[(NUM_WORDS-1-i)*WORD_W +: WORD_W];
      end
      round_nxt   = '0;
      w_valid_nxt = 1'b1;
    end else if (next && w_valid) begin
      if (round == ROUND_W'(63)) begin
        round_nxt   = '0;
        w_valid_nxt = 1'b0;
        done_nxt    = 1'b1;
      end else begin
        // Window slides only once the generated words are being consumed
        if (round[5:4] != 2'b00) begin
          for (int i = 0; i < NUM_WORDS - 1; i++) begin
            w_mem_nxt[i] = w_mem[i+1];
          end
          w_mem_nxt[NUM_WORDS-1] = w_new;
        end
        round_nxt = round + ROUND_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        w_mem[i] <= '0;
      end
      round   <= '0;
      w_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      w_mem   <= w_mem_nxt;
      round   <= round_nxt;
      w_valid <= w_valid_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_sha256_w_sched.sv
// Scoreboard bench for sha256_w_sched: a reference schedule model queues expected
// (W, round) pairs; a negedge monitor compares them as the DUT presents rounds.
module tb_sha256_w_sched;

  typedef struct {
    logic [31:0] w;
    logic [5:0]  r;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [511:0] block = '0;
  logic         init = 1'b0;
  logic         next = 1'b0;
  logic [31:0]  w;
  logic [5:0]   round;
  logic         w_valid;
  logic         done;

  int   n_checks = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  logic done_exp = 1'b0;
  exp_t exp_q[$];

  sha256_w_sched dut (
    .clk(clk), .reset(reset), .block(block), .init(init), .next(next),
    .w(w), .round(round), .w_valid(w_valid), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Textbook 64-entry schedule expansion
  function automatic void push_model(input logic [511:0] blk);
    logic [31:0] ws [64];
    for (int t = 0; t < 16; t++) ws[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) ws[t] = s1(ws[t-2]) + ws[t-7] + s0(ws[t-15]) + ws[t-16];
    for (int t = 0; t < 64; t++) exp_q.push_back('{ws[t], 6'(t)});
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Monitor: checks presented round against the queue, pops on accepted next
  always @(negedge clk) begin
    logic pop63;
    if (reset) begin
      done_exp = 1'b0;
    end else begin
      chk("done", 64'(done), 64'(done_exp));
      if (done) done_cnt++;
      chk("w_valid", 64'(w_valid), 64'(exp_q.size() != 0));
      pop63 = 1'b0;
      if (w_valid && exp_q.size() != 0) begin
        chk("w", 64'(w), 64'(exp_q[0].w));
        chk("round", 64'(round), 64'(exp_q[0].r));
        if (next && !init) begin
          pop63 = (exp_q[0].r == 6'd63);
          void'(exp_q.pop_front());
        end
      end
      done_exp = pop63;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic [511:0] blk);
    block = blk;
    init = 1'b1;
    step();
    init = 1'b0;
    block = rand_block();
    exp_q.delete();
    push_model(blk);
    chk("init_round", 64'(round), 64'd0);
    chk("init_valid", 64'(w_valid), 64'd1);
    chk("init_w0", 64'(w), 64'(blk[511:480]));
  endtask

  task automatic run_until_round(input logic [5:0] r);
    int cyc = 0;
    while (round != r && cyc < 200) begin
      step();
      cyc++;
    end
    chk("reach_round", 64'(round), 64'(r));
  endtask

  task automatic run_until_empty(input bit rnd);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 1000) begin
      if (rnd) next = 1'($urandom_range(0, 1));
      else next = 1'b1;
      step();
      cyc++;
    end
    next = 1'b0;
    chk("block_complete", 64'(exp_q.size()), 64'd0);
    repeat (2) step();
  endtask

  initial begin
    logic [511:0] abc;
    logic [511:0] b2;
    int dc;
    abc = {32'h61626380, 448'h0, 32'h00000018};

    // 1: reset then idle, next ignored
    repeat (2) step();
    reset = 1'b0;
    chk("rst_round", 64'(round), 64'd0);
    chk("rst_w", 64'(w), 64'd0);
    chk("rst_valid", 64'(w_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    for (int i = 0; i < 5; i++) begin
      next = 1'b1;
      step();
      next = 1'b0;
      step();
      chk("idle_round", 64'(round), 64'd0);
      chk("idle_w", 64'(w), 64'd0);
    end
    chk("idle_done_cnt", 64'(done_cnt), 64'd0);

    // 2: "abc" block with next every cycle plus known schedule words
    do_init(abc);
    next = 1'b1;
    for (int k = 0; k < 64; k++) begin
      chk("abc_round", 64'(round), 64'(k));
      if (k == 0)  chk("abc_W0", 64'(w), 64'h61626380);
      if (k == 15) chk("abc_W15", 64'(w), 64'h00000018);
      if (k == 16) chk("abc_W16", 64'(w), 64'h61626380);
      if (k == 17) chk("abc_W17", 64'(w), 64'h000F0000);
      if (k == 18) chk("abc_W18", 64'(w), 64'h7DA86405);
      step();
    end
    next = 1'b0;
    chk("abc_done", 64'(done), 64'd1);
    chk("abc_valid_drop", 64'(w_valid), 64'd0);
    chk("abc_round_wrap", 64'(round), 64'd0);
    step();
    chk("abc_done_pulse", 64'(done), 64'd0);

    // 3: same block, random next gating
    dc = done_cnt;
    do_init(abc);
    run_until_empty(1'b1);
    chk("rand_done_once", 64'(done_cnt), 64'(dc + 1));

    // 4: re-init mid-block at round 37
    dc = done_cnt;
    do_init(rand_block());
    next = 1'b1;
    run_until_round(6'd37);
    b2 = rand_block();
    do_init(b2);
    run_until_empty(1'b0);
    chk("reinit_done_once", 64'(done_cnt), 64'(dc + 1));

    // 5: init and next together at round 20
    dc = done_cnt;
    do_init(rand_block());
    next = 1'b1;
    run_until_round(6'd20);
    do_init(rand_block());
    run_until_empty(1'b1);
    chk("initnext_done_once", 64'(done_cnt), 64'(dc + 1));

    // 6: async reset between edges at round 50
    dc = done_cnt;
    do_init(rand_block());
    next = 1'b1;
    run_until_round(6'd50);
    next = 1'b0;
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("async_valid", 64'(w_valid), 64'd0);
    chk("async_round", 64'(round), 64'd0);
    chk("async_done", 64'(done), 64'd0);
    chk("async_w", 64'(w), 64'd0);
    #1;
    reset = 1'b0;
    step();
    chk("after_rst_done_cnt", 64'(done_cnt), 64'(dc));
    do_init(rand_block());
    run_until_empty(1'b1);
    chk("clean_done_once", 64'(done_cnt), 64'(dc + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
